// File: rtl/aes_pkg.sv
// Shared AES key-schedule helpers: key-size functions, Rcon seed, xtime, FSM states.
// Latency: none (constants and pure functions).
// Backpressure: not applicable.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        DRAIN = 2'd2
    } keyExpState_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic int nk_of(input int keyBits);
        return keyBits / 32;
    endfunction

    function automatic int nr_of(input int keyBits);
        return keyBits / 32 + 6;
    endfunction

    function automatic logic keyBitsLegal(input int keyBits);
        return (keyBits == 128) || (keyBits == 192) || (keyBits == 256);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_seq_subword.sv
// SubWord: forward AES S-box applied to each byte of a 32-bit word.
// Latency: combinational.
// Backpressure: none.
module aes_key_expand_seq_subword (
    input  logic [31:0] wordIn,
    output logic [31:0] wordOut
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always_comb begin
        wordOut = '0;
        for (int k = 0; k < 4; k++) begin
            wordOut[8*k +: 8] = SBOX[wordIn[8*k +: 8]];
        end
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key expansion: one schedule word per cycle from an Nk-word window, 128-bit round keys out.
// Latency: first round key valid 4 cycles after start is accepted; one round key per 4 cycles with rk_ready high.
// Backpressure: word generation stalls (counter, window, Rcon hold) while rk_valid && !rk_ready.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk_data,
    output logic [3:0]          rk_index,
    output logic                done
);

    localparam int NK     = nk_of(KEY_BITS);
    localparam int NR     = nr_of(KEY_BITS);
    localparam int NWORDS = 4 * (NR + 1);

    localparam logic [5:0] NK_M1     = 6'(NK - 1);
    localparam logic [5:0] LAST_WORD = 6'(NWORDS - 1);
    localparam logic [2:0] MOD_LAST  = 3'(NK - 1);

    if (!keyBitsLegal(KEY_BITS)) begin : gIllegalKeyBits
        $error("aes_key_expand_seq: KEY_BITS must be 128, 192 or 256");
    end

    keyExpState_t state, stateNext;

    // window[NK-1] is the oldest word w[i-NK], window[0] the newest w[i-1]
    logic [NK-1:0][31:0] window;
    logic [5:0]          wordCnt;
    logic [2:0]          modCnt;
    logic [7:0]          rcon;
    logic [2:0][31:0]    partBuf;

    logic        wrEn;
    logic        handshake;
    logic        firstPass;
    logic [31:0] keyWord;
    logic [31:0] sbIn;
    logic [31:0] sbOut;
    logic [31:0] temp;
    logic [31:0] newWord;

    aes_key_expand_seq_subword uSubWord (
        .wordIn  (sbIn),
        .wordOut (sbOut)
    );

    always_comb begin
        handshake = rk_valid && rk_ready;
        wrEn      = (state == GEN) && (!rk_valid || rk_ready);
        firstPass = (wordCnt <= NK_M1);

        // During the first pass the window still holds the key as loaded
        keyWord = '0;
        for (int j = 0; j < NK; j++) begin
            if (modCnt == 3'(j)) keyWord = window[NK-1-j];
        end

        sbIn = (modCnt == 3'd0) ? {window[0][23:0], window[0][31:24]} : window[0];

        if (modCnt == 3'd0)
            temp = sbOut ^ {rcon, 24'h0};
        else if (NK == 8 && modCnt == 3'd4)
            temp = sbOut;
        else
            temp = window[0];

        newWord = firstPass ? keyWord : (window[NK-1] ^ temp);
    end

    always_comb begin
        stateNext = state;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (start) stateNext = GEN;
            GEN:     if (wrEn && wordCnt == LAST_WORD) stateNext = DRAIN;
            DRAIN:   if (handshake) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window   <= '0;
            wordCnt  <= '0;
            modCnt   <= '0;
            rcon     <= '0;
            partBuf  <= '0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_index <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == DRAIN) && handshake;

            if (state == IDLE && start) begin
                window  <= key_in;
                wordCnt <= '0;
                modCnt  <= '0;
                rcon    <= RCON_INIT;
            end else if (wrEn) begin
                wordCnt <= wordCnt + 6'd1;
                modCnt  <= (modCnt == MOD_LAST) ? 3'd0 : modCnt + 3'd1;
                if (!firstPass) begin
                    window <= {window[NK-2:0], newWord};
                    if (modCnt == 3'd0) rcon <= xtime(rcon);
                end
                if (wordCnt[1:0] == 2'd3) begin
                    rk_data  <= {partBuf[0], partBuf[1], partBuf[2], newWord};
                    rk_index <= wordCnt[5:2];
                end else begin
                    partBuf[wordCnt[1:0]] <= newWord;
                end
            end

            // A group completing on a handshake edge keeps rk_valid high
            if (wrEn && wordCnt[1:0] == 2'd3)
                rk_valid <= 1'b1;
            else if (handshake)
                rk_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: three instances (128/192/256) against a FIPS-197 style reference model.
// Latency: n/a.
// Backpressure: driven by the bench through rk_ready.
module tb_aes_key_expand_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start   [3];
    logic         rkReady [3];
    logic         busy    [3];
    logic         rkValid [3];
    logic         done    [3];
    logic [127:0] rkData  [3];
    logic [3:0]   rkIndex [3];
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;

    aes_key_expand_seq #(.KEY_BITS(128)) u128 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .key_in(key128), .busy(busy[0]),
        .rk_valid(rkValid[0]), .rk_ready(rkReady[0]), .rk_data(rkData[0]),
        .rk_index(rkIndex[0]), .done(done[0]));

    aes_key_expand_seq #(.KEY_BITS(192)) u192 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .key_in(key192), .busy(busy[1]),
        .rk_valid(rkValid[1]), .rk_ready(rkReady[1]), .rk_data(rkData[1]),
        .rk_index(rkIndex[1]), .done(done[1]));

    aes_key_expand_seq #(.KEY_BITS(256)) u256 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .key_in(key256), .busy(busy[2]),
        .rk_valid(rkValid[2]), .rk_ready(rkReady[2]), .rk_data(rkData[2]),
        .rk_index(rkIndex[2]), .done(done[2]));

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox  [256];
    logic [31:0]  refW  [60];
    logic [127:0] seen  [15];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: S-box derived from GF(2^8) inversion plus the affine map
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic void buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [31:0] subRef(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic void refExpand(input int nk, input logic [255:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        int          nwords;
        nwords = 4 * (nk + 7);
        rc = 8'h01;
        for (int i = 0; i < nwords; i++) begin
            if (i < nk) begin
                refW[i] = key[255 - 32*i -: 32];
            end else begin
                t = refW[i-1];
                if (i % nk == 0) begin
                    t = subRef({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subRef(t);
                end
                refW[i] = refW[i-nk] ^ t;
            end
        end
    endfunction

    function automatic logic [127:0] refRk(input int r);
        return {refW[4*r], refW[4*r+1], refW[4*r+2], refW[4*r+3]};
    endfunction

    task automatic setKey(input int inst, input logic [255:0] key);
        case (inst)
            0:       key128 = key[255:128];
            1:       key192 = key[255:64];
            default: key256 = key;
        endcase
    endtask

    // mode 0: rk_ready high, 1: random rk_ready plus start-while-busy, 2: 7-cycle stall at round 3
    task automatic runExp(input int inst, input int nk, input logic [255:0] key,
                          input int mode, input int abortIdx);
        int nr, r, cyc, stallLeft, firstValid, lastValid;
        bit stalled, doneEarly;
        nr = nk + 6;
        r = 0; cyc = 0; stallLeft = 0; firstValid = -1; lastValid = -1;
        stalled = 1'b0; doneEarly = 1'b0;
        refExpand(nk, key);

        @(negedge clk);
        setKey(inst, key);
        start[inst]   = 1'b1;
        rkReady[inst] = 1'b1;
        @(posedge clk);

        while (r <= nr && cyc < 3000) begin
            @(negedge clk);
            if (cyc == 0) chk("busy_after_start", 128'(busy[inst]), 128'd1);
            start[inst] = (mode == 1 && cyc >= 10 && cyc < 13);
            if (mode == 1 && cyc == 10) setKey(inst, ~key);
            if (mode == 1 && cyc == 12) chk("busy_during_ignored_start", 128'(busy[inst]), 128'd1);

            if (abortIdx >= 0 && rkValid[inst] && rkIndex[inst] == 4'(abortIdx)) begin
                rst_n = 1'b0;
                start[inst] = 1'b0;
                #1;
                chk("abort_valid", 128'(rkValid[inst]), 128'd0);
                chk("abort_data", rkData[inst], 128'd0);
                chk("abort_index", 128'(rkIndex[inst]), 128'd0);
                chk("abort_busy", 128'(busy[inst]), 128'd0);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (done[inst]) doneEarly = 1'b1;
                end
                chk("abort_no_done", 128'(doneEarly), 128'd0);
                rst_n = 1'b1;
                return;
            end

            if (mode == 2 && !stalled && rkValid[inst] && rkIndex[inst] == 4'd3) begin
                stalled   = 1'b1;
                stallLeft = 7;
            end
            if (mode == 2 && stallLeft > 0) begin
                rkReady[inst] = 1'b0;
                chk("stall_data", rkData[inst], refRk(3));
                chk("stall_index", 128'(rkIndex[inst]), 128'd3);
                stallLeft--;
            end else begin
                rkReady[inst] = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end

            if (done[inst]) doneEarly = 1'b1;
            if (rkValid[inst] && firstValid < 0) firstValid = cyc;
            if (rkValid[inst] && rkReady[inst]) begin
                chk($sformatf("rk_data_r%0d", r), rkData[inst], refRk(r));
                chk($sformatf("rk_index_r%0d", r), 128'(rkIndex[inst]), 128'(r));
                seen[r] = rkData[inst];
                if (r == nr) lastValid = cyc;
                r++;
            end
            @(posedge clk);
            cyc++;
        end

        chk("all_round_keys_seen", 128'(r), 128'(nr + 1));
        chk("no_early_done", 128'(doneEarly), 128'd0);
        if (mode == 0) begin
            chk("first_valid_cycle", 128'(firstValid), 128'd4);
            chk("last_valid_cycle", 128'(lastValid), 128'(4 * (nr + 1)));
        end
        @(negedge clk);
        rkReady[inst] = 1'b1;
        chk("done_pulse", 128'(done[inst]), 128'd1);
        chk("idle_after_done", 128'(busy[inst]), 128'd0);
        chk("valid_low_after_done", 128'(rkValid[inst]), 128'd0);
        @(negedge clk);
        chk("done_one_cycle", 128'(done[inst]), 128'd0);
    endtask

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] rk;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start[k]   = 1'b0;
            rkReady[k] = 1'b1;
        end
        key128 = '0;
        key192 = '0;
        key256 = '0;
        buildSbox();

        repeat (3) @(negedge clk);
        chk("reset_busy", 128'(busy[0]), 128'd0);
        chk("reset_valid", 128'(rkValid[0]), 128'd0);
        chk("reset_data", rkData[0], 128'd0);
        chk("reset_index", 128'(rkIndex[0]), 128'd0);
        chk("reset_done", 128'(done[0]), 128'd0);
        rst_n = 1'b1;

        runExp(0, 4, K128, 0, -1);
        chk("k128_rk1", seen[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("k128_rk10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        runExp(1, 6, K192, 0, -1);
        chk("k192_w6", 128'(seen[1][63:32]), 128'hfe0c91f7);
        chk("k192_w51", 128'(seen[12][31:0]), 128'h01002202);

        runExp(2, 8, K256, 0, -1);
        chk("k256_w8", 128'(seen[2][127:96]), 128'h9ba35411);
        chk("k256_w12", 128'(seen[3][127:96]), 128'ha8b09c1a);
        chk("k256_rk14", seen[14], 128'hfe4890d1e6188d0b046df344706c631e);

        runExp(0, 4, K128, 2, -1);
        runExp(0, 4, K128, 1, -1);
        chk("k128_random_ready_rk10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        for (int n = 0; n < 3; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            runExp(n, 4 + 2*n, rk, 1, -1);
        end

        runExp(0, 4, K128, 0, 5);
        runExp(0, 4, K128, 0, -1);
        chk("k128_after_reset_rk10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
